// File: rtl/tmp_meas_sched_pkg.sv
// Shared types and default constants for the temperature-sensor measurement scheduler.
package tmp_pkg;

  localparam int TMP_CNT_W       = 16;
  localparam int TMP_RST_CYC     = 4;
  localparam int TMP_SETTLE_CYC  = 64;
  localparam int TMP_TIMEOUT_CYC = 1024;
  localparam int TMP_OSR_MAX     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_SETTLE,
    ST_SYNC,
    ST_MEASURE,
    ST_DONE,
    ST_WAIT
  } tmp_sched_state_t;

  // An oversampling setting of zero selects the longest window.
  function automatic logic [8:0] tmp_osr_frames(input logic [7:0] osr);
    return (osr == 8'd0) ? 9'(TMP_OSR_MAX) : {1'b0, osr};
  endfunction

endpackage

// File: rtl/tmp_meas_sched_if.sv
// Result handshake between the measurement scheduler and the readout logic above it.
interface tmp_meas_sched_if import tmp_pkg::*; #(
  parameter int CNT_W = TMP_CNT_W
);

  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_src;
  logic [CNT_W-1:0] res_tot;
  logic             res_sat;
  logic             res_err;

  modport master (
    output res_valid, res_src, res_tot, res_sat, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_src, res_tot, res_sat, res_err,
    output res_ready
  );

endinterface

// File: rtl/tmp_meas_sched_evt_cnt.sv
// Saturating event counter taking 0, 1 or 2 events per cycle, with a sticky overflow flag.
module tmp_evt_cnt import tmp_pkg::*; #(
  parameter int CNT_W = TMP_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W:0] sum;

  always_comb begin
    sum = {1'b0, count} + {{(CNT_W-1){1'b0}}, inc};
  end

  // The flag is set only when an increment would have carried past the top value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      if (sum > CNT_MAX) begin
        count <= CNT_MAX[CNT_W-1:0];
        sat   <= 1'b1;
      end else begin
        count <= sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tmp_meas_sched.sv
// Measurement scheduler: resets and settles the sensor core, aligns a window to its
// frame strobe, counts source/sink charge events and hands the result upward.
module tmp_meas_sched import tmp_pkg::*; #(
  parameter int CNT_W       = TMP_CNT_W,
  parameter int RST_CYC     = TMP_RST_CYC,
  parameter int SETTLE_CYC  = TMP_SETTLE_CYC,
  parameter int TIMEOUT_CYC = TMP_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        periodic,
  input  logic [15:0] period,
  input  logic [7:0]  osr,
  output logic        core_reset,
  input  logic        core_src_n,
  input  logic        core_snk,
  input  logic        core_frame,
  output logic        busy,
  tmp_meas_sched_if.master res
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  tmp_sched_state_t state;

  logic src_q, src_d, snk_q, snk_d, frm_q, frm_d;
  logic src_evt, snk_evt, frame_edge;

  logic [31:0]      timer;
  logic [TMO_W-1:0] tmo;
  logic [8:0]       frm_cnt;
  logic [8:0]       osr_q;
  logic             res_valid_q;
  logic             res_err_q;

  logic             cnt_clr, cnt_en;
  logic [1:0]       src_inc, tot_inc;
  logic [CNT_W-1:0] src_cnt, tot_cnt;
  logic             src_sat, tot_sat;

  // Core pins are asynchronous to us: one capture stage, then a history stage for edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q <= 1'b0;
      src_d <= 1'b0;
      snk_q <= 1'b0;
      snk_d <= 1'b0;
      frm_q <= 1'b0;
      frm_d <= 1'b0;
    end else begin
      src_q <= core_src_n;
      src_d <= src_q;
      snk_q <= core_snk;
      snk_d <= snk_q;
      frm_q <= core_frame;
      frm_d <= frm_q;
    end
  end

  assign src_evt    = src_q ^ src_d;
  assign snk_evt    = snk_q ^ snk_d;
  assign frame_edge = frm_q & ~frm_d;

  // Counters sit cleared for all of SYNC, so the opening frame edge drops its own events.
  assign cnt_clr = (state == ST_SYNC);
  assign cnt_en  = (state == ST_MEASURE);
  assign src_inc = {1'b0, src_evt};
  assign tot_inc = {1'b0, src_evt} + {1'b0, snk_evt};

  tmp_evt_cnt #(.CNT_W(CNT_W)) u_src_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .inc     (src_inc),
    .count   (src_cnt),
    .sat     (src_sat)
  );

  tmp_evt_cnt #(.CNT_W(CNT_W)) u_tot_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .inc     (tot_inc),
    .count   (tot_cnt),
    .sat     (tot_sat)
  );

  assign res.res_valid = res_valid_q;
  assign res.res_src   = src_cnt;
  assign res.res_tot   = tot_cnt;
  assign res.res_sat   = src_sat | tot_sat;
  assign res.res_err   = res_err_q;

  // Scheduler FSM; one shared timer serves the core-reset, settle and inter-measurement waits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      timer       <= '0;
      tmo         <= '0;
      frm_cnt     <= '0;
      osr_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CRST;
            busy  <= 1'b1;
            timer <= '0;
          end
        end
        ST_CRST: begin
          if (timer == 32'(RST_CYC - 1)) begin
            state      <= ST_SETTLE;
            core_reset <= 1'b0;
            timer      <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (timer == 32'(SETTLE_CYC - 1)) begin
            state     <= ST_SYNC;
            tmo       <= '0;
            res_err_q <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_SYNC: begin
          if (frame_edge) begin
            state   <= ST_MEASURE;
            osr_q   <= tmp_osr_frames(osr);
            frm_cnt <= '0;
            tmo     <= '0;
          end else if (tmo == TMO_LAST) begin
            state       <= ST_DONE;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (frame_edge) begin
            tmo <= '0;
            if (frm_cnt + 9'd1 == osr_q) begin
              state       <= ST_DONE;
              res_valid_q <= 1'b1;
            end else begin
              frm_cnt <= frm_cnt + 9'd1;
            end
          end else if (tmo == TMO_LAST) begin
            state       <= ST_DONE;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_DONE: begin
          if (res.res_ready) begin
            res_valid_q <= 1'b0;
            timer       <= '0;
            if (periodic) begin
              state <= ST_WAIT;
            end else begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              core_reset <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!periodic) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            core_reset <= 1'b1;
          end else if (timer + 32'd1 >= 32'(period)) begin
            state     <= ST_SYNC;
            tmo       <= '0;
            res_err_q <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmp_meas_sched.sv
// Bench for tmp_meas_sched: two instances (16-bit and 4-bit counters) share one stimulus
// stream; expected counts come from pin-level transition counting over each window.
module tb_tmp_meas_sched;
  import tmp_pkg::*;

  localparam int SMALL_MAX = 15;

  logic        clk = 1'b0;
  logic        reset_n, start, periodic, res_ready;
  logic [15:0] period;
  logic [7:0]  osr;
  logic        core_src_n, core_snk, core_frame;
  logic        core_reset_a, busy_a, core_reset_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  tmp_meas_sched_if #(.CNT_W(16)) res_a ();
  tmp_meas_sched_if #(.CNT_W(4))  res_b ();

  assign res_a.res_ready = res_ready;
  assign res_b.res_ready = res_ready;

  tmp_meas_sched #(.CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .periodic(periodic), .period(period),
    .osr(osr), .core_reset(core_reset_a), .core_src_n(core_src_n), .core_snk(core_snk),
    .core_frame(core_frame), .busy(busy_a), .res(res_a)
  );

  tmp_meas_sched #(.CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .periodic(periodic), .period(period),
    .osr(osr), .core_reset(core_reset_b), .core_src_n(core_src_n), .core_snk(core_snk),
    .core_frame(core_frame), .busy(busy_b), .res(res_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end, want end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk) res_ready = 1'b1;
    @(negedge clk) res_ready = 1'b0;
  endtask

  // Drives pins cycle by cycle; frames rise at multiples of frm_per, the first one opens the
  // window and the n_frames-th after it closes it. Events in (open, close] are expected.
  task automatic run_window(input int frm_per, input int n_frames, input int mode, input int start_k,
                            output int e_src, output int e_tot, output int valid_k, output int rst_hi);
    int   k_o, k_c;
    logic s_t, k_t;
    k_o = frm_per;
    k_c = (n_frames + 1) * frm_per;
    e_src = 0; e_tot = 0; valid_k = -1; rst_hi = 0;
    for (int k = 1; k <= k_c + 6; k++) begin
      @(negedge clk);
      if (valid_k < 0 && res_a.res_valid === 1'b1) valid_k = k;
      if (core_reset_a === 1'b1) rst_hi++;
      case (mode)
        0:       begin s_t = (k % 3 == 0); k_t = (k % 5 == 0); end
        1:       begin s_t = ($urandom_range(0, 2) == 0); k_t = ($urandom_range(0, 3) == 0); end
        default: begin s_t = (k > k_o && k <= k_o + 20); k_t = 1'b0; end
      endcase
      core_src_n = core_src_n ^ s_t;
      core_snk   = core_snk ^ k_t;
      core_frame = (k >= frm_per) && (k % frm_per < 3) && (k <= k_c);
      start      = (k == start_k);
      if (k > k_o && k <= k_c) begin
        e_src += int'(s_t);
        e_tot += int'(s_t) + int'(k_t);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; periodic = 1'b0; res_ready = 1'b0;
    period = 16'd0; osr = 8'd4; core_src_n = 1'b0; core_snk = 1'b0; core_frame = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %0b want 0", busy_a); end
    n_cmp++; if (core_reset_a !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_core_reset: got %0b want 1", core_reset_a); end
    n_cmp++; if (res_a.res_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %0b want 0", res_a.res_valid); end
    n_cmp++; if (res_a.res_src !== 16'd0 || res_a.res_tot !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_counts: got %0d/%0d want 0/0", res_a.res_src, res_a.res_tot); end
    n_cmp++; if (res_a.res_sat !== 1'b0 || res_a.res_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_flags: got sat %0b err %0b want 0 0", res_a.res_sat, res_a.res_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_single_shot();
    int hi, e_src, e_tot, v_k, r_hi;
    periodic = 1'b0; osr = 8'd4;
    pulse_start();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL ss_busy_latency: got %0b want 1", busy_a); end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_reset_a === 1'b1) hi++;
      @(negedge clk);
    end
    n_cmp++; if (hi != TMP_RST_CYC) begin n_bad++; $display("[TB] FAIL ss_core_reset_len: got %0d want %0d", hi, TMP_RST_CYC); end
    repeat (60) @(negedge clk);
    run_window(40, 4, 0, 100, e_src, e_tot, v_k, r_hi);
    n_cmp++; if (res_a.res_src !== 16'(e_src)) begin n_bad++; $display("[TB] FAIL ss_src: got %0d want %0d", res_a.res_src, e_src); end
    n_cmp++; if (res_a.res_tot !== 16'(e_tot)) begin n_bad++; $display("[TB] FAIL ss_tot: got %0d want %0d", res_a.res_tot, e_tot); end
    n_cmp++; if (v_k != 5 * 40 + 2) begin n_bad++; $display("[TB] FAIL ss_valid_time: got %0d want %0d", v_k, 5 * 40 + 2); end
    n_cmp++; if (r_hi != 0) begin n_bad++; $display("[TB] FAIL ss_start_ignored: got %0d core_reset cycles want 0", r_hi); end
    n_cmp++; if (res_a.res_sat !== 1'b0 || res_a.res_err !== 1'b0) begin n_bad++; $display("[TB] FAIL ss_flags: got sat %0b err %0b want 0 0", res_a.res_sat, res_a.res_err); end
    n_cmp++; if (res_b.res_src !== 4'((e_src > SMALL_MAX) ? SMALL_MAX : e_src)) begin n_bad++; $display("[TB] FAIL ss_small_src: got %0d want %0d", res_b.res_src, (e_src > SMALL_MAX) ? SMALL_MAX : e_src); end
    n_cmp++; if (res_b.res_sat !== (e_tot > SMALL_MAX)) begin n_bad++; $display("[TB] FAIL ss_small_sat: got %0b want %0b", res_b.res_sat, e_tot > SMALL_MAX); end
    handshake();
    n_cmp++; if (res_a.res_valid !== 1'b0 || busy_a !== 1'b0 || core_reset_a !== 1'b1) begin n_bad++; $display("[TB] FAIL ss_after_hs: got valid %0b busy %0b core_reset %0b want 0 0 1", res_a.res_valid, busy_a, core_reset_a); end
  endtask

  task automatic test_random();
    int frm, nf, e_src, e_tot, v_k, r_hi, e_bs, e_bt;
    periodic = 1'b0;
    for (int it = 0; it < 3; it++) begin
      frm = $urandom_range(8, 30);
      nf  = $urandom_range(1, 6);
      osr = 8'(nf);
      pulse_start();
      repeat (90) @(negedge clk);
      run_window(frm, nf, 1, 0, e_src, e_tot, v_k, r_hi);
      e_bs = (e_src > SMALL_MAX) ? SMALL_MAX : e_src;
      e_bt = (e_tot > SMALL_MAX) ? SMALL_MAX : e_tot;
      n_cmp++; if (res_a.res_src !== 16'(e_src)) begin n_bad++; $display("[TB] FAIL rnd%0d_src: got %0d want %0d", it, res_a.res_src, e_src); end
      n_cmp++; if (res_a.res_tot !== 16'(e_tot)) begin n_bad++; $display("[TB] FAIL rnd%0d_tot: got %0d want %0d", it, res_a.res_tot, e_tot); end
      n_cmp++; if (v_k != (nf + 1) * frm + 2) begin n_bad++; $display("[TB] FAIL rnd%0d_valid_time: got %0d want %0d", it, v_k, (nf + 1) * frm + 2); end
      n_cmp++; if (res_b.res_src !== 4'(e_bs) || res_b.res_tot !== 4'(e_bt)) begin n_bad++; $display("[TB] FAIL rnd%0d_small: got %0d/%0d want %0d/%0d", it, res_b.res_src, res_b.res_tot, e_bs, e_bt); end
      n_cmp++; if (res_b.res_sat !== (e_tot > SMALL_MAX)) begin n_bad++; $display("[TB] FAIL rnd%0d_small_sat: got %0b want %0b", it, res_b.res_sat, e_tot > SMALL_MAX); end
      handshake();
    end
  endtask

  task automatic test_saturation();
    int e_src, e_tot, v_k, r_hi;
    periodic = 1'b0; osr = 8'd1;
    pulse_start();
    repeat (90) @(negedge clk);
    run_window(30, 1, 2, 0, e_src, e_tot, v_k, r_hi);
    n_cmp++; if (res_a.res_src !== 16'(e_src) || res_a.res_sat !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_wide: got %0d sat %0b want %0d sat 0", res_a.res_src, res_a.res_sat, e_src); end
    n_cmp++; if (res_b.res_src !== 4'(SMALL_MAX)) begin n_bad++; $display("[TB] FAIL sat_small_src: got %0d want %0d", res_b.res_src, SMALL_MAX); end
    n_cmp++; if (res_b.res_sat !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_small_flag: got %0b want 1", res_b.res_sat); end
    handshake();
  endtask

  task automatic test_timeout();
    int cyc;
    periodic = 1'b0; osr = 8'd4;
    pulse_start();
    cyc = 0;
    while (res_a.res_valid !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc != TMP_RST_CYC + TMP_SETTLE_CYC + TMP_TIMEOUT_CYC) begin n_bad++; $display("[TB] FAIL tmo_latency: got %0d want %0d", cyc, TMP_RST_CYC + TMP_SETTLE_CYC + TMP_TIMEOUT_CYC); end
    n_cmp++; if (res_a.res_err !== 1'b1 || res_b.res_err !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_err: got %0b/%0b want 1/1", res_a.res_err, res_b.res_err); end
    n_cmp++; if (res_a.res_src !== 16'd0 || res_a.res_tot !== 16'd0) begin n_bad++; $display("[TB] FAIL tmo_counts: got %0d/%0d want 0/0", res_a.res_src, res_a.res_tot); end
    handshake();
  endtask

  task automatic test_periodic();
    int e_src, e_tot, v_k, r_hi, cyc;
    periodic = 1'b1; period = 16'd10; osr = 8'd2;
    pulse_start();
    repeat (90) @(negedge clk);
    run_window(20, 2, 1, 0, e_src, e_tot, v_k, r_hi);
    n_cmp++; if (res_a.res_src !== 16'(e_src) || res_a.res_tot !== 16'(e_tot)) begin n_bad++; $display("[TB] FAIL per1_counts: got %0d/%0d want %0d/%0d", res_a.res_src, res_a.res_tot, e_src, e_tot); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++; if (res_a.res_valid !== 1'b1 || res_a.res_src !== 16'(e_src) || res_a.res_tot !== 16'(e_tot) || res_a.res_err !== 1'b0) begin n_bad++; $display("[TB] FAIL stall%0d: got v%0b %0d/%0d e%0b want v1 %0d/%0d e0", i, res_a.res_valid, res_a.res_src, res_a.res_tot, res_a.res_err, e_src, e_tot); end
    end
    osr = 8'd0;
    handshake();
    n_cmp++; if (res_a.res_valid !== 1'b0 || busy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL per_hs: got valid %0b busy %0b want 0 1", res_a.res_valid, busy_a); end
    run_window(12, TMP_OSR_MAX, 1, 0, e_src, e_tot, v_k, r_hi);
    n_cmp++; if (r_hi != 0) begin n_bad++; $display("[TB] FAIL per2_no_core_reset: got %0d want 0", r_hi); end
    n_cmp++; if (v_k != (TMP_OSR_MAX + 1) * 12 + 2) begin n_bad++; $display("[TB] FAIL per2_valid_time: got %0d want %0d", v_k, (TMP_OSR_MAX + 1) * 12 + 2); end
    n_cmp++; if (res_a.res_src !== 16'(e_src) || res_a.res_tot !== 16'(e_tot)) begin n_bad++; $display("[TB] FAIL per2_counts: got %0d/%0d want %0d/%0d", res_a.res_src, res_a.res_tot, e_src, e_tot); end
    handshake();
    cyc = 0;
    while (res_a.res_valid !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc != 10 + TMP_TIMEOUT_CYC) begin n_bad++; $display("[TB] FAIL per_wait_len: got %0d want %0d", cyc, 10 + TMP_TIMEOUT_CYC); end
    n_cmp++; if (res_a.res_err !== 1'b1 || core_reset_a !== 1'b0) begin n_bad++; $display("[TB] FAIL per3_err: got err %0b core_reset %0b want 1 0", res_a.res_err, core_reset_a); end
    periodic = 1'b0;
    handshake();
    n_cmp++; if (busy_a !== 1'b0 || core_reset_a !== 1'b1) begin n_bad++; $display("[TB] FAIL per_exit: got busy %0b core_reset %0b want 0 1", busy_a, core_reset_a); end
  endtask

  task automatic test_abort();
    periodic = 1'b0; osr = 8'd8;
    pulse_start();
    repeat (90) @(negedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 49) begin
        n_cmp++; if (busy_a !== 1'b1 || res_a.res_src === 16'd0) begin n_bad++; $display("[TB] FAIL abort_pre: got busy %0b src %0d want 1 and nonzero", busy_a, res_a.res_src); end
      end
      if (k == 51) begin
        n_cmp++; if (busy_a !== 1'b0 || core_reset_a !== 1'b1 || res_a.res_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_ctrl: got busy %0b core_reset %0b valid %0b want 0 1 0", busy_a, core_reset_a, res_a.res_valid); end
        n_cmp++; if (res_a.res_src !== 16'd0 || res_a.res_tot !== 16'd0 || res_a.res_sat !== 1'b0 || res_a.res_err !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_results: got %0d/%0d sat %0b err %0b want 0/0 0 0", res_a.res_src, res_a.res_tot, res_a.res_sat, res_a.res_err); end
      end
      reset_n    = (k != 50);
      core_src_n = core_src_n ^ (k % 2 == 0);
      core_frame = (k >= 20) && (k % 20 < 3);
    end
    core_frame = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0 || res_a.res_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_stays_idle: got busy %0b valid %0b want 0 0", busy_a, res_a.res_valid); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_random();
    test_saturation();
    test_timeout();
    test_periodic();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tmp_meas_sched.md
# tmp_meas_sched

Measurement scheduler for the temperature-sensor switched-capacitor core. It resets and settles the core, then opens a measurement window aligned to the core's output phase. During the window it counts source and sink charge events over a programmable number of conversion frames. The result is presented on a valid/ready handshake, either single-shot or periodically, to the register/readout logic above it.

## Interface
- `CNT_W`, 16: width of event counters and result fields.
- `RST_CYC`, 4: cycles `core_reset` is held high after a start.
- `SETTLE_CYC`, 64: cycles waited after core reset release before frame sync.
- `TIMEOUT_CYC`, 1024: maximum cycles between frame edges in SYNC/MEASURE before error.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle request; honoured only in IDLE.
- `periodic` in 1: when high, repeat measurements after each handshake.
- `period` in 16: idle cycles between periodic measurements.
- `osr` in 8: frames per window; 0 means 256.
- `core_reset` out 1: active-high reset to the sensor core.
- `core_src_n` in 1: core source switch; every transition is one source event.
- `core_snk` in 1: core sink switch; every transition is one sink event.
- `core_frame` in 1: core output-phase strobe (PD); a rising edge marks a frame boundary.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_src` out CNT_W: source events in the window.
- `res_tot` out CNT_W: source plus sink events in the window.
- `res_sat` out 1: a counter saturated.
- `res_err` out 1: frame timeout; counts are invalid.

## Operation
- Inputs `core_src_n`, `core_snk` and `core_frame` are registered once. An event is the XOR of the current and previous registered value; a frame is a registered rising edge.
- States: IDLE, CRST, SETTLE, SYNC, MEASURE, DONE, WAIT.
- IDLE: `start`=1 leads to CRST. Otherwise the block stays in IDLE.
- CRST: `core_reset`=1 for RST_CYC cycles, then SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then SYNC.
- SYNC: wait for a frame edge. The counters clear on that edge, and the block enters MEASURE.
- MEASURE:
  - `res_src` += source event.
  - `res_tot` += (source event + sink event); simultaneous source and sink events add 2.
  - A frame counter increments on each frame edge. When it reaches the `osr` frame edge, the block enters DONE.
  - `osr` is sampled on SYNC exit.
- DONE: `res_valid`=1 and all result fields are held stable. When `res_valid`&&`res_ready`:
  - `periodic`=1 leads to WAIT.
  - Otherwise the block returns to IDLE.
- WAIT: count `period` cycles, then SYNC. The core is not reset again. `period`=0 goes to SYNC on the next cycle. Deasserting `periodic` in WAIT leads to IDLE.
- Counters saturate at 2^CNT_W−1, which sets a sticky `res_sat` for the window.
- Timeout: if the cycles since the last frame edge (or since SYNC entry) reach TIMEOUT_CYC in SYNC or MEASURE:
  - `res_err`=1 and the block enters DONE.
  - Counts are as accumulated when the timeout fired.
- `res_sat` and `res_err` clear on SYNC entry.

## Timing
- Reset values:
  - State IDLE.
  - `core_reset`=1; it stays 1 in IDLE and is 0 from SETTLE onward.
  - `busy`=0, `res_valid`=0, `res_src`=0, `res_tot`=0, `res_sat`=0, `res_err`=0.
- All outputs are registered.
- `start` latency: `busy` rises in the cycle after `start`.
- `core_reset` stays high during CRST, then drops.
- Events reach the counters 2 cycles after the input pin changes (input register plus edge register).
- The frame edge that opens the window is not counted as a frame. Events that coincide with the closing frame edge are counted.
- `res_valid` rises the cycle after the closing frame edge. It stays high until the handshake and falls the cycle after it.
- `start` outside IDLE is ignored.
- `reset_n` low mid-measurement aborts:
  - The block returns to reset values the next cycle.
  - Any partial result is discarded.

## Structure
- Package `tmp_pkg`:
  - `tmp_sched_state_t` enum.
  - Default parameter constants.
  - `TMP_OSR_MAX`=256.
- Sub-module `tmp_evt_cnt`: saturating CNT_W counter with clear, an increment of 0/1/2, and a sticky saturation flag. It is instantiated twice.
- Top FSM, edge registers, frame/timeout/period counters stay in `tmp_meas_sched`.

## Test plan
- Single shot, `osr`=4, source toggles every 3 cycles, sink every 5, frames every 40 cycles → `res_valid` after 4 frames; `res_src`=53, `res_tot`=85 (±1 at window edges per bench model); `res_sat`=0.
- `start` pulse while in MEASURE → ignored. Pulse in IDLE → `core_reset` high for exactly 4 cycles; SETTLE lasts 64 cycles.
- `core_frame` held low after SETTLE → `res_err`=1 and `res_valid` after 1024 cycles in SYNC.
- CNT_W=4, continuous source toggles for 20 cycles in window → `res_src`=15, `res_sat`=1.
- `periodic`=1, `period`=10, `res_ready` stalled 7 cycles → outputs stable during stall. After the handshake, WAIT lasts 10 cycles, the next window starts with no `core_reset`, and `osr`=0 yields 256 frames.
- `reset_n` low for one cycle mid-MEASURE → IDLE, `core_reset`=1, `busy`=0, results 0 on the following cycle.
